// File: rtl/sfr_pipe_flow_ctrl.sv
// Flow controller for a clock-enabled, fixed-latency pipeline. It tracks valid and SOF bits per stage,
// buffers the pipeline output in a 2-entry valid/ready FIFO, and runs the drain-then-clear flush sequence.
module sfr_pipe_flow_ctrl #(
    parameter int LATENCY    = 4,
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_user,
    output logic                  pipe_clken,
    output logic                  pipe_sclr,
    input  logic [DATA_WIDTH-1:0] pipe_data_out,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_user,
    input  logic                  flush_req,
    output logic                  flush_busy,
    output logic                  flush_done
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [LATENCY-1:0]    vld_q, vld_d;
    logic [LATENCY-1:0]    usr_q, usr_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  flush_done_q, flush_done_d;
    logic [DATA_WIDTH:0]   mem_q [2];

    logic                  accept;
    logic                  push;
    logic                  pop;

    // The FIFO's last free slot is the only thing that can stall the pipeline. This keeps the enable
    // a function of registered state alone, so m_ready never reaches pipe_clken combinationally.
    assign pipe_clken = (state_q == CLEAR) || (cnt_q != 2'd2);
    assign pipe_sclr  = (state_q == CLEAR);
    assign s_ready    = (state_q == RUN) && pipe_clken;
    assign flush_busy = (state_q != RUN);
    assign flush_done = flush_done_q;

    assign accept  = s_valid && s_ready;
    assign push    = pipe_clken && vld_q[LATENCY-1];
    assign m_valid = (cnt_q != 2'd0);
    assign pop     = m_valid && m_ready;
    assign m_data  = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
    assign m_user  = mem_q[rd_ptr_q][DATA_WIDTH];

    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        case (state_q)
            RUN: begin
                if (flush_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((vld_q == '0) && (cnt_q == 2'd0)) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d      = RUN;
                flush_done_d = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Per-stage valid/SOF bits shift in lockstep with the datapath registers.
    always_comb begin
        vld_d = vld_q;
        usr_d = usr_q;
        if (state_q == CLEAR) begin
            vld_d = '0;
            usr_d = '0;
        end else if (pipe_clken) begin
            vld_d[0] = accept;
            usr_d[0] = s_user;
            for (int i = 1; i < LATENCY; i++) begin
                vld_d[i] = vld_q[i-1];
                usr_d[i] = usr_q[i-1];
            end
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 2'd1;
        end
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= RUN;
            vld_q        <= '0;
            usr_q        <= '0;
            cnt_q        <= 2'd0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vld_q        <= vld_d;
            usr_q        <= usr_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            flush_done_q <= flush_done_d;
        end
    end

    // Storage is reset as well so m_data/m_user read zero out of reset.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= {usr_q[LATENCY-1], pipe_data_out};
        end
    end

endmodule

// File: doc/sfr_pipe_flow_ctrl.md
Name: sfr_pipe_flow_ctrl

Overview:
- Flow controller for a fixed-latency, clock-enabled shift/compute pipeline built from clock-enable shift-register stages in the bicubic upscaler datapath.
- Generates the shared clock enable (pipe_clken) and synchronous clear (pipe_sclr) for the pipeline, and tracks per-stage valid and start-of-frame bits alongside the data.
- Captures pipeline output into a 2-entry output FIFO with a valid/ready interface, so downstream backpressure stalls the whole pipeline cleanly.
- Sequences a frame-boundary flush: drain the pipeline, then clear it.

Parameters:
- LATENCY, 4, pipeline depth in clken-gated register stages (>=1).
- DATA_WIDTH, 24, width of pipeline output data (pipe_data_out, m_data).

Ports:
- clk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_user  in  1  start-of-frame marker for the input beat.
- pipe_clken  out  1  clock enable to every pipeline stage.
- pipe_sclr  out  1  synchronous clear to every pipeline stage; the datapath acts on it only while pipe_clken=1.
- pipe_data_out  in  DATA_WIDTH  last pipeline stage output.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream ready.
- m_data  out  DATA_WIDTH  output data.
- m_user  out  1  start-of-frame marker of the output beat.
- flush_req  in  1  single-cycle request to drain and clear the pipeline.
- flush_busy  out  1  high while in DRAIN or CLEAR.
- flush_done  out  1  single-cycle pulse when CLEAR completes.

Behaviour:
- Reset is aresetn, asynchronous, active-low; clock is clk.
- Reset values:
  - state=RUN, vld[LATENCY-1:0]=0, usr[]=0, FIFO count=0.
  - m_valid=0, m_user=0, m_data=0.
  - flush_busy=0, flush_done=0, pipe_sclr=0.
  - pipe_clken is combinational from state and count, so it reads 1 during reset.
- FSM states: RUN, DRAIN, CLEAR.
  - RUN: pipe_clken = (cnt!=2); s_ready = pipe_clken.
  - RUN -> DRAIN on flush_req. A beat accepted in that same cycle is kept.
  - DRAIN: s_ready=0; pipe_clken = (cnt!=2), which shifts bubbles into the pipeline.
  - DRAIN -> CLEAR when vld==0 && cnt==0.
  - CLEAR: exactly 1 cycle with pipe_clken=1, pipe_sclr=1, s_ready=0; vld and usr forced to 0.
  - CLEAR -> RUN, with flush_done=1 registered in the cycle after CLEAR.
  - flush_req is ignored in DRAIN and CLEAR.
- Valid tracking, on each edge with pipe_clken=1 and not in CLEAR:
  - vld[0] <= s_valid && s_ready; usr[0] <= s_user.
  - vld[i] <= vld[i-1]; usr[i] <= usr[i-1].
  - With pipe_clken=0, vld and usr hold.
- FIFO push: on an edge where pipe_clken && vld[LATENCY-1], push {usr[LATENCY-1], pipe_data_out}.
- FIFO pop: m_valid && m_ready.
- FIFO count rules:
  - Push and pop in the same cycle leaves count unchanged.
  - Count never exceeds 2: clken=0 at cnt=2 blocks any push.
  - Pop at cnt=2 re-enables clken the next cycle (no combinational m_ready->clken path).
- Output ordering: m_data/m_user are driven from the FIFO head, FIFO order preserved.
- Latency with no stall: beat accepted at edge t gives m_valid=1 after edge t+LATENCY, i.e. LATENCY+1 cycles from acceptance to presentation.
- Backpressure: with m_ready=0 indefinitely, exactly 2 beats are held in the FIFO plus up to LATENCY in the pipeline. No beat is lost or duplicated.
- Bubbles (vld=0) are never pushed to the FIFO.
- Reset mid-operation: all state clears asynchronously; in-flight beats are discarded; no flush_done pulse.

Test Plan:
- LATENCY=4, m_ready=1, send beats 0x000001..0x000008 back-to-back, first with s_user=1 -> m_data 1..8 in order, first m_valid 5 cycles after first acceptance, m_user=1 only on 0x000001, s_ready stays 1.
- Hold m_ready=0, send 10 beats -> s_ready drops after 6 accepted (2 FIFO + 4 stages), pipe_clken=0. Release m_ready -> all 10 beats emerge in order, no gaps lost.
- 3 beats in flight, pulse flush_req -> s_ready=0; the 3 beats are delivered; one cycle with pipe_clken=1 && pipe_sclr=1; flush_done pulses once; s_ready returns to 1.
- flush_req with empty pipeline and FIFO -> DRAIN lasts 1 cycle, CLEAR 1 cycle, flush_done pulse, flush_busy high 2 cycles.
- Random s_valid and m_ready over 2000 cycles against a reference queue -> output sequence equals input sequence, cnt<=2, no m_data change while m_valid && !m_ready.
- Deassert aresetn while stalled with full FIFO -> m_valid=0 immediately, cnt=0, vld=0; after release, first new beat emerges with normal latency.
